// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester and peripheral signals of the SPI arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the requesters and the SPI peripheral.
`timescale 1ns/1ps
interface spi_arbiter_if;
    // Requester side
    logic        req0_i;
    logic        req1_i;
    logic [4:0]  cfg0_i;
    logic [4:0]  cfg1_i;
    logic [7:0]  wdata0_i;
    logic [7:0]  wdata1_i;
    logic        gnt0_o;
    logic        gnt1_o;
    logic        done0_o;
    logic        done1_o;
    logic        err0_o;
    logic        err1_o;
    logic [15:0] rdata_o;
    logic        busy_o;
    // Peripheral side
    logic [5:0]  per_statusreg_o;
    logic [7:0]  per_data_o;
    logic        per_doneflag_i;
    logic [15:0] per_data_i;

    modport master (
        input  req0_i, req1_i, cfg0_i, cfg1_i, wdata0_i, wdata1_i,
        input  per_doneflag_i, per_data_i,
        output gnt0_o, gnt1_o, done0_o, done1_o, err0_o, err1_o,
        output rdata_o, busy_o, per_statusreg_o, per_data_o
    );

    modport slave (
        output req0_i, req1_i, cfg0_i, cfg1_i, wdata0_i, wdata1_i,
        output per_doneflag_i, per_data_i,
        input  gnt0_o, gnt1_o, done0_o, done1_o, err0_o, err1_o,
        input  rdata_o, busy_o, per_statusreg_o, per_data_o
    );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester arbiter for a single SPI peripheral.
// Each transaction is a sequence of phases:
// - SETUP: the configuration is presented with start low.
// - RUN: start is raised until the peripheral reports done or the wait times out.
// - RELEASE: start is dropped until the peripheral clears its done flag.
// All outputs are registered. Their next values are decoded from the next state.
`timescale 1ns/1ps
module spi_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned SETUP_CYCLES = 2
) (
    input  logic           spi_clk_i,
    input  logic           spi_rst_i,
    spi_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Last counter value of a phase. A phase ends on the edge where the counter equals this value.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);
    localparam logic [15:0] SU_LAST = 16'(SETUP_CYCLES - 32'd1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_cfg;
    logic [7:0]  r_wdata;
    logic        r_owner;
    logic        r_last;
    logic        r_err_seen;
    logic [15:0] r_rdata;
    logic        r_gnt0, r_gnt1, r_done0, r_done1, r_err0, r_err1, r_busy;
    logic [5:0]  r_status;
    logic [7:0]  r_pdata;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [4:0]  w_cfg_nxt;
    logic [7:0]  w_wdata_nxt;
    logic        w_owner_nxt;
    logic        w_last_nxt;
    logic        w_err_seen_nxt;
    logic [15:0] w_rdata_nxt;
    logic        w_win;
    logic        w_done;
    logic        w_err;
    logic        w_busy_nxt;
    logic [5:0]  w_status_nxt;
    logic [7:0]  w_pdata_nxt;

    // State and output registers. A reset clears them asynchronously, which drops start at once.
    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 16'd0;
            r_cfg      <= 5'd0;
            r_wdata    <= 8'd0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_err_seen <= 1'b0;
            r_rdata    <= 16'd0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_busy     <= 1'b0;
            r_status   <= 6'd0;
            r_pdata    <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cfg      <= w_cfg_nxt;
            r_wdata    <= w_wdata_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_err_seen <= w_err_seen_nxt;
            r_rdata    <= w_rdata_nxt;
            r_gnt0     <= w_busy_nxt & ~w_owner_nxt;
            r_gnt1     <= w_busy_nxt &  w_owner_nxt;
            r_done0    <= w_done & ~r_owner;
            r_done1    <= w_done &  r_owner;
            r_err0     <= w_err & ~r_owner;
            r_err1     <= w_err &  r_owner;
            r_busy     <= w_busy_nxt;
            r_status   <= w_status_nxt;
            r_pdata    <= w_pdata_nxt;
        end
    end

    // Next-state logic: arbitration, latching of the winner's request, completion and timeout handling.
    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_nxt      = r_cfg;
        w_wdata_nxt    = r_wdata;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_err_seen_nxt = r_err_seen;
        w_rdata_nxt    = r_rdata;
        w_win          = 1'b0;
        w_done         = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_err_seen_nxt = 1'b0;
                // When both requesters ask, the one not served last wins.
                if (bus.req0_i && bus.req1_i) begin
                    w_win = ~r_last;
                end else if (bus.req0_i) begin
                    w_win = 1'b0;
                end else begin
                    w_win = 1'b1;
                end
                if (bus.req0_i || bus.req1_i) begin
                    w_state_nxt = ST_SETUP;
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_cfg_nxt   = w_win ? bus.cfg1_i   : bus.cfg0_i;
                    w_wdata_nxt = w_win ? bus.wdata1_i : bus.wdata0_i;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt >= SU_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_RUN: begin
                // A done flag wins over a timeout that expires on the same edge.
                if (bus.per_doneflag_i) begin
                    w_rdata_nxt = bus.per_data_i;
                    w_done      = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (r_cnt >= TO_LAST) begin
                    w_err          = 1'b1;
                    w_err_seen_nxt = 1'b1;
                    w_state_nxt    = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RELEASE: begin
                if (!bus.per_doneflag_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt >= TO_LAST) begin
                    // A transaction that already reported a RUN timeout gets no second error pulse.
                    w_err       = ~r_err_seen;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase counter: cleared on every state change and held at zero while idle.
    always_comb begin
        w_cnt_nxt = 16'd0;
        if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
            w_cnt_nxt = 16'd0;
        end else begin
            w_cnt_nxt = r_cnt + 16'd1;
        end
    end

    // Next value of the peripheral outputs, decoded from the state being entered.
    always_comb begin
        w_status_nxt = 6'd0;
        w_pdata_nxt  = 8'd0;
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_IDLE: begin
                w_status_nxt = 6'd0;
                w_pdata_nxt  = 8'd0;
            end
            ST_SETUP: begin
                w_status_nxt = {w_cfg_nxt, 1'b0};
                w_pdata_nxt  = w_wdata_nxt;
            end
            ST_RUN: begin
                w_status_nxt = {w_cfg_nxt, 1'b1};
                w_pdata_nxt  = w_wdata_nxt;
            end
            ST_RELEASE: begin
                w_status_nxt = {w_cfg_nxt, 1'b0};
                w_pdata_nxt  = w_wdata_nxt;
            end
            default: begin
                w_status_nxt = 6'd0;
                w_pdata_nxt  = 8'd0;
            end
        endcase
    end

    assign bus.gnt0_o          = r_gnt0;
    assign bus.gnt1_o          = r_gnt1;
    assign bus.done0_o         = r_done0;
    assign bus.done1_o         = r_done1;
    assign bus.err0_o          = r_err0;
    assign bus.err1_o          = r_err1;
    assign bus.rdata_o         = r_rdata;
    assign bus.busy_o          = r_busy;
    assign bus.per_statusreg_o = r_status;
    assign bus.per_data_o      = r_pdata;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed test of spi_arbiter.
// dut uses the default parameters. dut20 uses TIMEOUT=20 for the timeout cases.
`timescale 1ns/1ps
module tb_spi_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic overlap_seen;
    logic acc;

    spi_arbiter_if bus ();
    spi_arbiter_if bus20 ();

    spi_arbiter dut (
        .spi_clk_i (clk),
        .spi_rst_i (rst),
        .bus       (bus)
    );

    spi_arbiter #(.TIMEOUT(20), .SETUP_CYCLES(2)) dut20 (
        .spi_clk_i (clk),
        .spi_rst_i (rst),
        .bus       (bus20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant overlap monitor for the main instance.
    always @(negedge clk) begin
        if (bus.gnt0_o && bus.gnt1_o) overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction on the main instance. Entry is just after the grant edge; exit is the first IDLE cycle.
    task automatic xact(input logic own, input logic [4:0] cfg, input logic [7:0] wd,
                        input int n_run, input int n_hold, input logic [15:0] rd);
        check("grant_gnt0", {31'd0, bus.gnt0_o}, {31'd0, ~own});
        check("grant_gnt1", {31'd0, bus.gnt1_o}, {31'd0, own});
        check("setup1_status", {26'd0, bus.per_statusreg_o}, {26'd0, cfg, 1'b0});
        check("setup_data", {24'd0, bus.per_data_o}, {24'd0, wd});
        check("setup_busy", {31'd0, bus.busy_o}, 32'd1);
        tick();
        check("setup2_status", {26'd0, bus.per_statusreg_o}, {26'd0, cfg, 1'b0});
        tick();
        check("run1_status", {26'd0, bus.per_statusreg_o}, {26'd0, cfg, 1'b1});
        for (int i = 1; i < n_run; i++) tick();
        check("runN_status", {26'd0, bus.per_statusreg_o}, {26'd0, cfg, 1'b1});
        bus.per_doneflag_i = 1'b1;
        bus.per_data_i     = rd;
        tick();
        bus.per_data_i     = 16'h0000;
        check("done0", {31'd0, bus.done0_o}, {31'd0, ~own});
        check("done1", {31'd0, bus.done1_o}, {31'd0, own});
        check("rdata", {16'd0, bus.rdata_o}, {16'd0, rd});
        check("release_status", {26'd0, bus.per_statusreg_o}, {26'd0, cfg, 1'b0});
        for (int i = 0; i < n_hold; i++) begin
            tick();
            check("done_pulse_end", {30'd0, bus.done1_o, bus.done0_o}, 32'd0);
            check("hold_status", {26'd0, bus.per_statusreg_o}, {26'd0, cfg, 1'b0});
        end
        bus.per_doneflag_i = 1'b0;
        tick();
        check("idle_status", {26'd0, bus.per_statusreg_o}, 32'd0);
        check("idle_data", {24'd0, bus.per_data_o}, 32'd0);
        check("idle_busy", {31'd0, bus.busy_o}, 32'd0);
        check("idle_gnt", {30'd0, bus.gnt1_o, bus.gnt0_o}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        overlap_seen = 1'b0;
        rst = 1'b1;
        bus.req0_i = 1'b0;    bus.req1_i = 1'b0;
        bus.cfg0_i = 5'd0;    bus.cfg1_i = 5'd0;
        bus.wdata0_i = 8'd0;  bus.wdata1_i = 8'd0;
        bus.per_doneflag_i = 1'b0; bus.per_data_i = 16'd0;
        bus20.req0_i = 1'b0;   bus20.req1_i = 1'b0;
        bus20.cfg0_i = 5'd0;   bus20.cfg1_i = 5'd0;
        bus20.wdata0_i = 8'd0; bus20.wdata1_i = 8'd0;
        bus20.per_doneflag_i = 1'b0; bus20.per_data_i = 16'd0;

        // Reset state, before any clock edge.
        #1;
        check("rst_gnt", {30'd0, bus.gnt1_o, bus.gnt0_o}, 32'd0);
        check("rst_done_err", {28'd0, bus.err1_o, bus.err0_o, bus.done1_o, bus.done0_o}, 32'd0);
        check("rst_rdata", {16'd0, bus.rdata_o}, 32'd0);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_status", {26'd0, bus.per_statusreg_o}, 32'd0);
        check("rst_pdata", {24'd0, bus.per_data_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single transaction from requester 0, done flag in RUN cycle 160.
        bus.req0_i = 1'b1; bus.cfg0_i = 5'b01011; bus.wdata0_i = 8'hA8;
        tick();
        bus.req0_i = 1'b0; bus.cfg0_i = 5'h1F; bus.wdata0_i = 8'h00;
        xact(1'b0, 5'b01011, 8'hA8, 160, 3, 16'h1234);

        // Reset asserted for 1 ns in the middle of RUN.
        bus.req0_i = 1'b1; bus.cfg0_i = 5'b01011; bus.wdata0_i = 8'hA8;
        tick();
        bus.req0_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("pre_rst_start", {31'd0, bus.per_statusreg_o[0]}, 32'd1);
        rst = 1'b1;
        #0.5;
        check("mid_rst_status", {26'd0, bus.per_statusreg_o}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("mid_rst_gnt0", {31'd0, bus.gnt0_o}, 32'd0);
        check("mid_rst_rdata", {16'd0, bus.rdata_o}, 32'd0);
        #0.5;
        rst = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc = acc | bus.done0_o | bus.err0_o | bus.busy_o;
        end
        check("post_rst_quiet", {31'd0, acc}, 32'd0);
        bus.req0_i = 1'b1; bus.cfg0_i = 5'b01011; bus.wdata0_i = 8'hA8;
        tick();
        bus.req0_i = 1'b0;
        xact(1'b0, 5'b01011, 8'hA8, 160, 3, 16'h1234);

        // Both requesting and held: 0, then 1, then 0, with an idle cycle between grants.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        bus.req0_i = 1'b1; bus.req1_i = 1'b1;
        bus.cfg0_i = 5'h03; bus.cfg1_i = 5'h1C;
        bus.wdata0_i = 8'h11; bus.wdata1_i = 8'h22;
        tick();
        xact(1'b0, 5'h03, 8'h11, 1, 0, 16'h0A0A);
        tick();
        xact(1'b1, 5'h1C, 8'h22, 1, 0, 16'h0B0B);
        tick();
        xact(1'b0, 5'h03, 8'h11, 4, 1, 16'h0C0C);
        bus.req0_i = 1'b0; bus.req1_i = 1'b0;
        tick();
        check("gnt_overlap", {31'd0, overlap_seen}, 32'd0);

        // TIMEOUT=20: a successful requester-1 transfer, then one that never completes.
        bus20.req1_i = 1'b1; bus20.cfg1_i = 5'h15; bus20.wdata1_i = 8'h3C;
        tick();
        bus20.req1_i = 1'b0;
        tick(); tick();
        bus20.per_doneflag_i = 1'b1; bus20.per_data_i = 16'hBEEF;
        tick();
        bus20.per_doneflag_i = 1'b0; bus20.per_data_i = 16'h0000;
        check("t20_done1", {31'd0, bus20.done1_o}, 32'd1);
        check("t20_rdata", {16'd0, bus20.rdata_o}, 32'h0000BEEF);
        tick();
        bus20.req1_i = 1'b1;
        tick();
        bus20.req1_i = 1'b0;
        check("t20_gnt1", {31'd0, bus20.gnt1_o}, 32'd1);
        tick(); tick();
        for (int i = 1; i < 20; i++) tick();
        check("t20_run20_err", {31'd0, bus20.err1_o}, 32'd0);
        check("t20_run20_start", {31'd0, bus20.per_statusreg_o[0]}, 32'd1);
        tick();
        check("t20_err1", {31'd0, bus20.err1_o}, 32'd1);
        check("t20_err_start", {31'd0, bus20.per_statusreg_o[0]}, 32'd0);
        check("t20_rdata_kept", {16'd0, bus20.rdata_o}, 32'h0000BEEF);
        // Flag stuck in RELEASE after a RUN timeout: IDLE after 20 cycles, no second error pulse.
        bus20.per_doneflag_i = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            acc = acc | bus20.err1_o;
        end
        check("t20_rel_busy", {31'd0, bus20.busy_o}, 32'd1);
        tick();
        acc = acc | bus20.err1_o;
        check("t20_one_err", {31'd0, acc}, 32'd0);
        check("t20_idle_busy", {31'd0, bus20.busy_o}, 32'd0);
        bus20.per_doneflag_i = 1'b0;
        tick();

        // Done flag stuck high after completion: done pulse, then an error 20 cycles into RELEASE.
        bus20.req0_i = 1'b1; bus20.cfg0_i = 5'h0A; bus20.wdata0_i = 8'h5A;
        tick();
        bus20.req0_i = 1'b0;
        tick(); tick();
        bus20.per_doneflag_i = 1'b1; bus20.per_data_i = 16'hCAFE;
        tick();
        check("stuck_done0", {31'd0, bus20.done0_o}, 32'd1);
        check("stuck_rdata", {16'd0, bus20.rdata_o}, 32'h0000CAFE);
        for (int i = 1; i < 20; i++) tick();
        check("stuck_pre_err", {31'd0, bus20.err0_o}, 32'd0);
        check("stuck_pre_busy", {31'd0, bus20.busy_o}, 32'd1);
        tick();
        check("stuck_err0", {31'd0, bus20.err0_o}, 32'd1);
        check("stuck_idle_busy", {31'd0, bus20.busy_o}, 32'd0);
        check("stuck_idle_gnt0", {31'd0, bus20.gnt0_o}, 32'd0);
        check("stuck_idle_status", {26'd0, bus20.per_statusreg_o}, 32'd0);
        tick();
        check("stuck_err_pulse", {31'd0, bus20.err0_o}, 32'd0);
        bus20.per_doneflag_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in RUN or RELEASE before abort; legal range 1..65535.
REQ-002 Parameter SETUP_CYCLES, default 2: cycles the configuration is held with start=0 before start is raised; legal range 1..15.
REQ-003 spi_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 spi_rst_i  in  1  asynchronous, active-high reset.
REQ-005 req0_i, req1_i  in  1 each  transaction request, requester 0 and requester 1.
REQ-006 cfg0_i, cfg1_i  in  5 each  requester SPI configuration; maps to peripheral status bits [5:1].
REQ-007 wdata0_i, wdata1_i  in  8 each  requester byte to transmit.
REQ-008 gnt0_o, gnt1_o  out  1 each  requester owns the peripheral.
REQ-009 done0_o, done1_o  out  1 each  one-cycle pulse on successful completion.
REQ-010 err0_o, err1_o  out  1 each  one-cycle pulse on timeout abort.
REQ-011 rdata_o  out  16  last received word; shared by both requesters.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 per_statusreg_o  out  6  status register to the SPI peripheral; bit0 is start.
REQ-014 per_data_o  out  8  transmit byte to the SPI peripheral.
REQ-015 per_doneflag_i  in  1  peripheral done flag.
REQ-016 per_data_i  in  16  peripheral received word.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, RUN and RELEASE.
REQ-018 IDLE: on the first edge with any request sampled high, the FSM SHALL latch the winner's cfg and wdata, assert the winner's gnt, and enter SETUP.
REQ-019 Arbitration: a sole requester wins; if both request, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins first.
REQ-020 SETUP: per_statusreg_o = {cfg,0} and per_data_o = wdata for exactly SETUP_CYCLES cycles, then RUN.
REQ-021 RUN: per_statusreg_o = {cfg,1}; the cycle counter increments every cycle.
REQ-022 RUN, per_doneflag_i sampled high: capture per_data_i into rdata_o, pulse done for the owner, enter RELEASE.
REQ-023 RUN, counter reaches TIMEOUT with no done flag: pulse err for the owner, leave rdata_o unchanged, enter RELEASE.
REQ-024 RELEASE: per_statusreg_o = {cfg,0}; enter IDLE on the first cycle per_doneflag_i is sampled low.
REQ-025 RELEASE, done flag still high after TIMEOUT cycles: force IDLE and pulse err for the owner; at most one err pulse per transaction.
REQ-026 The cycle counter SHALL be 16 bits and clear on every state entry; TIMEOUT = 1 aborts after one cycle.
REQ-027 gnt SHALL stay high from SETUP through RELEASE and drop on IDLE entry.
REQ-028 A new grant SHALL NOT occur before the edge after IDLE entry, so a transaction gap is at least one IDLE cycle.
REQ-029 Requester inputs SHALL be ignored while busy; dropping req mid-transaction does not abort it.
REQ-030 Latched cfg and wdata SHALL be unaffected by input changes after the grant.
REQ-031 The last-served pointer SHALL update at grant.
REQ-032 IDLE: per_statusreg_o = 0 and per_data_o = 0.

Reset
REQ-033 With spi_rst_i high, all outputs, rdata_o, the counter and the latched cfg/wdata SHALL be 0, the state IDLE and the pointer 1, immediately and independent of the clock.
REQ-034 Reset mid-transaction SHALL drop start at once, with no done or err pulse.
REQ-035 After reset release, the first edge with a request SHALL grant normally.

Verification
REQ-036 Reset, any state -> all outputs 0 asynchronously; busy_o = 0.
REQ-037 req0, cfg0=01011, wdata0=A8, done flag at RUN cycle 160 with per_data_i=1234h -> statusreg 010110 for 2 cycles then 010111; done0 one cycle; rdata_o=1234h; statusreg 010110 until flag low, then 000000.
REQ-038 req0 and req1 high together, held -> requester 0 served, then 1, then 0; gnt never overlaps; at least one IDLE cycle between transactions.
REQ-039 TIMEOUT=20, done flag never asserted -> err1 pulses at RUN cycle 20; rdata_o keeps its prior value; FSM returns to IDLE.
REQ-040 Done flag stuck high after completion -> done pulse; err pulse TIMEOUT cycles into RELEASE; then IDLE.
REQ-041 spi_rst_i asserted mid-RUN for 1 ns -> start bit 0 at once; no done or err; next req0 is granted with statusreg sequence identical to REQ-037.
